// File: rtl/sbox_share_ctrl.sv
// ---------------------------------------------------------------------------
// sbox_share_ctrl
//
// Time-shares four AES S-box instances between the round datapath (SubBytes
// over a 128-bit state, one 32-bit word per cycle) and the key expansion
// (SubWord over a single 32-bit word, one cycle).
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   sb_req/sb_in     SubBytes request (level) and 128-bit state
//   sb_ack           one-cycle pulse, sb_in captured
//   sb_done/sb_out   one-cycle completion pulse, held substituted state
//   sw_req/sw_in     SubWord request (level) and 32-bit word
//   sw_ack           one-cycle pulse, sw_in captured
//   sw_done/sw_out   one-cycle completion pulse, held substituted word
//   busy             high whenever the sequencer is not idle
// Parameter:
//   KEY_PRIO         1: SubWord always wins contention, 0: round-robin
// ---------------------------------------------------------------------------

// AES forward S-box: multiplicative inverse in GF(2^8) followed by the
// affine transform. Computed rather than tabulated.
module sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 for x != 0, and 0 maps to 0 as AES requires.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv  = ginv(din);
        dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module sbox_share_ctrl #(
    parameter int KEY_PRIO = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sb_req,
    input  logic [127:0] sb_in,
    output logic         sb_ack,
    output logic         sb_done,
    output logic [127:0] sb_out,
    input  logic         sw_req,
    input  logic [31:0]  sw_in,
    output logic         sw_ack,
    output logic         sw_done,
    output logic [31:0]  sw_out,
    output logic         busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SB   = 2'd1;
    localparam logic [1:0] S_SW   = 2'd2;

    localparam logic G_SB = 1'b0;
    localparam logic G_SW = 1'b1;

    logic [1:0]        state;
    logic [1:0]        cnt;
    logic [3:0][31:0]  sbuf;      // working buffer ("buf" is a reserved word)
    logic              last_grant;

    logic [3:0][7:0]   sel_word;
    logic [3:0][7:0]   sub_word;
    logic              grant_sw;
    logic              grant_sb;

    assign sel_word = sbuf[cnt];

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        sbox u_sbox (
            .din  (sel_word[i]),
            .dout (sub_word[i])
        );
    end

    // SubWord wins unless round-robin says SubBytes is due.
    always_comb begin
        grant_sw = sw_req && (!sb_req || (KEY_PRIO != 0) || (last_grant == G_SB));
        grant_sb = sb_req && !grant_sw;
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 2'd0;
            sbuf       <= '0;
            last_grant <= G_SB;
            sb_out     <= '0;
            sw_out     <= '0;
            sb_ack     <= 1'b0;
            sw_ack     <= 1'b0;
            sb_done    <= 1'b0;
            sw_done    <= 1'b0;
        end else begin
            sb_ack  <= 1'b0;
            sw_ack  <= 1'b0;
            sb_done <= 1'b0;
            sw_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_sw) begin
                        sbuf[0]    <= sw_in;
                        cnt        <= 2'd0;
                        state      <= S_SW;
                        sw_ack     <= 1'b1;
                        last_grant <= G_SW;
                    end else if (grant_sb) begin
                        sbuf       <= sb_in;
                        cnt        <= 2'd0;
                        state      <= S_SB;
                        sb_ack     <= 1'b1;
                        last_grant <= G_SB;
                    end
                end
                S_SB: begin
                    sbuf[cnt] <= sub_word;
                    cnt       <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        // Last word bypasses the buffer so sb_out lands this edge.
                        sb_out  <= {sub_word, sbuf[2], sbuf[1], sbuf[0]};
                        sb_done <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                S_SW: begin
                    sw_out  <= sub_word;
                    sw_done <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sbox_share_ctrl.sv
module tb_sbox_share_ctrl;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sb_req = 1'b0, sw_req = 1'b0;
    logic [127:0] sb_in = '0;
    logic [31:0]  sw_in = '0;
    logic         sb_ack, sb_done, sw_ack, sw_done, busy;
    logic [127:0] sb_out;
    logic [31:0]  sw_out;

    logic         rr_sb_req = 1'b0, rr_sw_req = 1'b0;
    logic         rr_sb_ack, rr_sb_done, rr_sw_ack, rr_sw_done, rr_busy;
    logic [127:0] rr_sb_out;
    logic [31:0]  rr_sw_out;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] SB_A_IN  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SB_A_OUT = 128'h637c777bf26b6fc53001672bfed7ab76;
    localparam logic [127:0] SB_B_IN  = 128'h5355ff01000102030405060708090a0b;
    localparam logic [127:0] SB_B_OUT = 128'hedfc167c637c777bf26b6fc53001672b;
    localparam logic [127:0] SB_Z_OUT = {16{8'h63}};
    localparam logic [127:0] SB_C_IN  = {4{32'h5355ff01}};
    localparam logic [127:0] SB_C_OUT = {4{32'hedfc167c}};

    always #5 clk = ~clk;

    sbox_share_ctrl #(.KEY_PRIO(1)) dut (
        .clk(clk), .rst(rst),
        .sb_req(sb_req), .sb_in(sb_in), .sb_ack(sb_ack), .sb_done(sb_done), .sb_out(sb_out),
        .sw_req(sw_req), .sw_in(sw_in), .sw_ack(sw_ack), .sw_done(sw_done), .sw_out(sw_out),
        .busy(busy)
    );

    sbox_share_ctrl #(.KEY_PRIO(0)) dut_rr (
        .clk(clk), .rst(rst),
        .sb_req(rr_sb_req), .sb_in(sb_in), .sb_ack(rr_sb_ack), .sb_done(rr_sb_done),
        .sb_out(rr_sb_out),
        .sw_req(rr_sw_req), .sw_in(sw_in), .sw_ack(rr_sw_ack), .sw_done(rr_sw_done),
        .sw_out(rr_sw_out),
        .busy(rr_busy)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Control flags packed {ack, done, busy} for compact per-cycle checks.
    function automatic logic [127:0] f3(input logic a, input logic d, input logic b);
        return {125'd0, a, d, b};
    endfunction

    initial begin
        // Reset state
        #12;
        check("rst_sb_out", sb_out, '0);
        check("rst_sw_out", {96'd0, sw_out}, '0);
        check("rst_flags", {123'd0, sb_ack, sb_done, sw_ack, sw_done, busy}, '0);
        rst = 1'b0;
        tick(1);

        // SubBytes: sampled at end of n, ack n+1, done n+5
        sb_in = SB_A_IN; sb_req = 1'b1;
        tick(1);
        check("sb1_n1", f3(sb_ack, sb_done, busy), f3(1, 0, 1));
        sb_req = 1'b0; sb_in = '1;
        tick(3);
        check("sb1_n4", f3(sb_ack, sb_done, busy), f3(0, 0, 1));
        tick(1);
        check("sb1_n5", f3(sb_ack, sb_done, busy), f3(0, 1, 0));
        check("sb1_out", sb_out, SB_A_OUT);
        check("sb1_swdone", {127'd0, sw_done}, '0);
        tick(1);
        check("sb1_n6", f3(sb_ack, sb_done, busy), f3(0, 0, 0));

        // SubWord: ack n+1, done n+2, sb_out untouched
        sw_in = 32'h5355ff01; sw_req = 1'b1;
        tick(1);
        check("sw_n1", f3(sw_ack, sw_done, busy), f3(1, 0, 1));
        sw_req = 1'b0; sw_in = '0;
        tick(1);
        check("sw_n2", f3(sw_ack, sw_done, busy), f3(0, 1, 0));
        check("sw_out", {96'd0, sw_out}, {96'd0, 32'hedfc167c});
        check("sw_sb_hold", sb_out, SB_A_OUT);
        tick(1);

        // Fixed priority: SW first, SB sampled in sw_done cycle, sb_done at n+7
        sw_in = 32'h00010203; sw_req = 1'b1;
        sb_in = SB_B_IN; sb_req = 1'b1;
        tick(1);
        check("fp_n1_sw", f3(sw_ack, sw_done, busy), f3(1, 0, 1));
        check("fp_n1_sb", {127'd0, sb_ack}, '0);
        sw_req = 1'b0;
        tick(1);
        check("fp_n2", f3(sw_ack, sw_done, busy), f3(0, 1, 0));
        check("fp_swout", {96'd0, sw_out}, {96'd0, 32'h637c777b});
        tick(1);
        check("fp_n3_sb", f3(sb_ack, sb_done, busy), f3(1, 0, 1));
        sb_req = 1'b0;
        tick(3);
        check("fp_n6", {127'd0, sb_done}, '0);
        tick(1);
        check("fp_n7", f3(sb_ack, sb_done, busy), f3(0, 1, 0));
        check("fp_sbout", sb_out, SB_B_OUT);
        tick(1);

        // Held request: second ack 6 cycles after the first sample
        sb_in = '0; sb_req = 1'b1;
        tick(1);
        check("hold_ack1", {127'd0, sb_ack}, {127'd0, 1'b1});
        sb_in = SB_C_IN;
        tick(4);
        check("hold_n5", f3(sb_ack, sb_done, busy), f3(0, 1, 0));
        check("hold_out1", sb_out, SB_Z_OUT);
        tick(1);
        check("hold_n6", f3(sb_ack, sb_done, busy), f3(1, 0, 1));
        sb_req = 1'b0;
        tick(4);
        check("hold_n10", f3(sb_ack, sb_done, busy), f3(0, 1, 0));
        check("hold_out2", sb_out, SB_C_OUT);
        tick(1);

        // Reset mid-operation at cnt=2 (third SB cycle)
        sb_in = SB_B_IN; sb_req = 1'b1;
        tick(1);
        sb_req = 1'b0;
        tick(2);
        rst = 1'b1;
        #1;
        check("mrst_sb_out", sb_out, '0);
        check("mrst_sw_out", {96'd0, sw_out}, '0);
        check("mrst_busy", {127'd0, busy}, '0);
        tick(2);
        rst = 1'b0;
        tick(4);
        check("mrst_nodone", f3(sb_ack, sb_done, busy), f3(0, 0, 0));
        check("mrst_out_zero", sb_out, '0);

        // Test 1 repeated after reset
        sb_in = SB_A_IN; sb_req = 1'b1;
        tick(1);
        check("sb2_n1", f3(sb_ack, sb_done, busy), f3(1, 0, 1));
        sb_req = 1'b0;
        tick(3);
        check("sb2_n4", {127'd0, sb_done}, '0);
        tick(1);
        check("sb2_n5", f3(sb_ack, sb_done, busy), f3(0, 1, 0));
        check("sb2_out", sb_out, SB_A_OUT);
        tick(1);

        // Round-robin with both requests held: SW, SB, SW, SB
        sb_in = SB_A_IN; sw_in = 32'h5355ff01;
        rr_sb_req = 1'b1; rr_sw_req = 1'b1;
        tick(1);
        check("rr_n1", {126'd0, rr_sw_ack, rr_sb_ack}, {126'd0, 2'b10});
        tick(1);
        check("rr_n2", f3(rr_sw_ack, rr_sw_done, rr_busy), f3(0, 1, 0));
        check("rr_swout", {96'd0, rr_sw_out}, {96'd0, 32'hedfc167c});
        tick(1);
        check("rr_n3", {126'd0, rr_sw_ack, rr_sb_ack}, {126'd0, 2'b01});
        tick(4);
        check("rr_n7", f3(rr_sb_ack, rr_sb_done, rr_busy), f3(0, 1, 0));
        check("rr_sbout", rr_sb_out, SB_A_OUT);
        tick(1);
        check("rr_n8", {126'd0, rr_sw_ack, rr_sb_ack}, {126'd0, 2'b10});
        tick(1);
        check("rr_n9", f3(rr_sw_ack, rr_sw_done, rr_busy), f3(0, 1, 0));
        tick(1);
        check("rr_n10", {126'd0, rr_sw_ack, rr_sb_ack}, {126'd0, 2'b01});
        rr_sb_req = 1'b0; rr_sw_req = 1'b0;
        tick(4);
        check("rr_n14", f3(rr_sb_ack, rr_sb_done, rr_busy), f3(0, 1, 0));
        tick(2);
        check("rr_idle", {127'd0, rr_busy}, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
